// File: rtl/shapool_job_ctrl.sv
// Host-side job loader and result reporter for the hashing pool.
// Assembles a 47-byte job, arms the pool, watches it, and returns a 5-byte result frame.
module shapool_job_ctrl #(
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned ARM_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_first,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    output logic [7:0]   res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic [255:0] sha_state,
    output logic [95:0]  message_head,
    output logic [15:0]  difficulty_bm,
    output logic [7:0]   nonce_start_MSB,
    output logic         pool_reset_n,
    input  logic         pool_success,
    input  logic [31:0]  pool_nonce
);

    localparam int unsigned NONCE_WIDTH = 32 - POOL_SIZE_LOG2;
    localparam logic [7:0]  ARM_LAST    = 8'(ARM_CYCLES - 1);
    localparam logic [5:0]  LAST_BYTE   = 6'd46;

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]   r_state;
    logic [5:0]   r_cnt;
    logic [7:0]   r_arm_cnt;
    logic [375:0] r_job;
    logic         r_pool_rst_n;
    logic         r_prev_msb;
    logic [7:0]   r_status;
    logic [31:0]  r_nonce;
    logic [2:0]   r_res_idx;
    logic [7:0]   r_res_data;
    logic         r_res_valid;

    logic         w_msb;
    logic         w_exhaust;
    logic         w_event;
    logic [7:0]   w_status;
    logic [31:0]  w_nonce;
    logic [7:0]   w_next_byte;
    logic [375:0] w_job_shift;

    assign w_msb       = pool_nonce[NONCE_WIDTH-1];
    // Counter MSB falling from 1 to 0 means the pool nonce counter wrapped.
    assign w_exhaust   = r_prev_msb & ~w_msb;
    assign w_event     = pool_success | abort | w_exhaust;
    assign w_job_shift = {r_job[367:0], in_data};

    always_comb begin
        w_status = 8'h00;
        w_nonce  = 32'h0;
        if (pool_success) begin
            w_status = 8'h01;
            w_nonce  = pool_nonce;
        end else if (abort) begin
            w_status = 8'h03;
            w_nonce  = pool_nonce;
        end else if (w_exhaust) begin
            w_status = 8'h02;
        end
    end

    always_comb begin
        w_next_byte = 8'h00;
        case (r_res_idx)
            3'd0:    w_next_byte = r_nonce[31:24];
            3'd1:    w_next_byte = r_nonce[23:16];
            3'd2:    w_next_byte = r_nonce[15:8];
            3'd3:    w_next_byte = r_nonce[7:0];
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_LOAD;
            r_cnt        <= 6'd0;
            r_arm_cnt    <= 8'd0;
            r_job        <= '0;
            r_pool_rst_n <= 1'b0;
            r_prev_msb   <= 1'b0;
            r_status     <= 8'h00;
            r_nonce      <= 32'h0;
            r_res_idx    <= 3'd0;
            r_res_data   <= 8'h00;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (abort) begin
                        r_cnt <= 6'd0;
                    end else if (in_valid) begin
                        if (in_first) begin
                            r_job <= w_job_shift;
                            r_cnt <= 6'd1;
                        end else if (r_cnt != 6'd0) begin
                            r_job <= w_job_shift;
                            if (r_cnt == LAST_BYTE) begin
                                r_cnt     <= 6'd0;
                                r_arm_cnt <= 8'd0;
                                r_state   <= S_ARM;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        r_cnt   <= 6'd0;
                        r_state <= S_LOAD;
                    end else if (r_arm_cnt == ARM_LAST) begin
                        r_pool_rst_n <= 1'b1;
                        r_prev_msb   <= 1'b0;
                        r_state      <= S_RUN;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    r_prev_msb <= w_msb;
                    if (w_event) begin
                        r_status     <= w_status;
                        r_nonce      <= w_nonce;
                        r_pool_rst_n <= 1'b0;
                        r_res_idx    <= 3'd0;
                        r_res_data   <= w_status;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        if (r_res_idx == 3'd4) begin
                            r_res_valid <= 1'b0;
                            r_state     <= S_LOAD;
                        end else begin
                            r_res_idx  <= r_res_idx + 3'd1;
                            r_res_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Gate with reset so the source sees no ready while the block is held in reset.
    assign in_ready        = (r_state == S_LOAD) & reset_n;
    assign busy            = (r_state == S_ARM) | (r_state == S_RUN);
    assign res_data        = r_res_data;
    assign res_valid       = r_res_valid;
    assign pool_reset_n    = r_pool_rst_n;
    assign sha_state       = r_job[375:120];
    assign message_head    = r_job[119:24];
    assign difficulty_bm   = r_job[23:8];
    assign nonce_start_MSB = r_job[7:0];

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Directed testbench for shapool_job_ctrl: job load, arming, result frames, priority, reset.
module tb_shapool_job_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_first;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [7:0]   res_data;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic [255:0] sha_state;
    logic [95:0]  message_head;
    logic [15:0]  difficulty_bm;
    logic [7:0]   nonce_start_MSB;
    logic         pool_reset_n;
    logic         pool_success;
    logic [31:0]  pool_nonce;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shapool_job_ctrl #(
        .POOL_SIZE_LOG2(1),
        .ARM_CYCLES    (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_first       (in_first),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .abort          (abort),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .busy           (busy),
        .sha_state      (sha_state),
        .message_head   (message_head),
        .difficulty_bm  (difficulty_bm),
        .nonce_start_MSB(nonce_start_MSB),
        .pool_reset_n   (pool_reset_n),
        .pool_success   (pool_success),
        .pool_nonce     (pool_nonce)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected 376-bit job for bytes base, base+1, ... base+46.
    function automatic logic [375:0] build_job(input logic [7:0] base);
        logic [375:0] j;
        j = '0;
        for (int i = 0; i < 47; i++) j = {j[367:0], 8'(base + 8'(i))};
        return j;
    endfunction

    task automatic send_bytes(input logic [7:0] base, input int n, input bit first);
        for (int i = 0; i < n; i++) begin
            in_data  = 8'(base + 8'(i));
            in_first = first && (i == 0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic load_and_run(input logic [7:0] base);
        send_bytes(base, 47, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b0 || pool_reset_n !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b prst=%b rv=%b busy=%b required 0 0 0 0",
                     in_ready, pool_reset_n, res_valid, busy);
        end
        checks++;
        if (res_data !== 8'h00 || sha_state !== 256'h0 || message_head !== 96'h0 ||
            difficulty_bm !== 16'h0 || nonce_start_MSB !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got res_data=%h sha=%h required all zero", res_data, sha_state);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_load();
        logic [375:0] ej;
        ej = build_job(8'h00);
        send_bytes(8'h00, 47, 1'b1);
        checks++;
        if (pool_reset_n !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL arm1: got prst=%b busy=%b rdy=%b required 0 1 0", pool_reset_n, busy, in_ready);
        end
        tick();
        checks++;
        if (pool_reset_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arm2: got prst=%b busy=%b required 0 1", pool_reset_n, busy);
        end
        tick();
        checks++;
        if (pool_reset_n !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: got prst=%b busy=%b required 1 1", pool_reset_n, busy);
        end
        checks++;
        if (sha_state !== ej[375:120] || message_head !== ej[119:24] ||
            difficulty_bm !== 16'h2C2D || nonce_start_MSB !== 8'h2E) begin
            errors++;
            $display("FAIL job_fields: got sha=%h head=%h diff=%h msb=%h required %h %h 2c2d 2e",
                     sha_state, message_head, difficulty_bm, nonce_start_MSB,
                     ej[375:120], ej[119:24]);
        end
    endtask

    task automatic test_success();
        logic [7:0] exp [5];
        exp = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD};
        pool_nonce   = 32'h1234ABCD;
        pool_success = 1'b1;
        res_ready    = 1'b1;
        tick();
        pool_success = 1'b0;
        checks++;
        if (pool_reset_n !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL success_prst: got prst=%b busy=%b required 0 0", pool_reset_n, busy);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp[k]) begin
                errors++;
                $display("FAIL success_byte%0d: got v=%b d=%h required 1 %h", k, res_valid, res_data, exp[k]);
            end
            tick();
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL success_end: got rv=%b rdy=%b required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5];
        exp = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD};
        pool_nonce = 32'h0;
        load_and_run(8'h00);
        pool_nonce   = 32'h1234ABCD;
        pool_success = 1'b1;
        res_ready    = 1'b1;
        tick();
        pool_success = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                res_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checks++;
                    if (res_valid !== 1'b1 || res_data !== 8'h34) begin
                        errors++;
                        $display("FAIL stall%0d: got v=%b d=%h required 1 34", s, res_valid, res_data);
                    end
                    tick();
                end
                res_ready = 1'b1;
            end
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp[k]) begin
                errors++;
                $display("FAIL bp_byte%0d: got v=%b d=%h required 1 %h", k, res_valid, res_data, exp[k]);
            end
            tick();
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got rv=%b required 0", res_valid);
        end
    endtask

    task automatic test_exhaust();
        logic [7:0] exp [5];
        exp = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        pool_nonce = 32'h0;
        load_and_run(8'h00);
        pool_nonce = 32'h7FFFFFFF;
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exh_early: got rv=%b busy=%b required 0 1", res_valid, busy);
        end
        pool_nonce = 32'h00000000;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp[k]) begin
                errors++;
                $display("FAIL exh_byte%0d: got v=%b d=%h required 1 %h", k, res_valid, res_data, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp_s [5];
        logic [7:0] exp_a [5];
        exp_s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
        exp_a = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h10};
        pool_nonce = 32'h0;
        load_and_run(8'h00);
        pool_nonce   = 32'h00000055;
        pool_success = 1'b1;
        abort        = 1'b1;
        tick();
        pool_success = 1'b0;
        // abort stays high through the frame; it must not disturb REPORT
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_s[k]) begin
                errors++;
                $display("FAIL prio_byte%0d: got v=%b d=%h required 1 %h", k, res_valid, res_data, exp_s[k]);
            end
            tick();
        end
        abort      = 1'b0;
        pool_nonce = 32'h0;
        load_and_run(8'h00);
        pool_nonce = 32'h00000010;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_a[k]) begin
                errors++;
                $display("FAIL abort_byte%0d: got v=%b d=%h required 1 %h", k, res_valid, res_data, exp_a[k]);
            end
            tick();
        end
    endtask

    task automatic test_refirst();
        logic [375:0] ej;
        ej = build_job(8'h50);
        pool_nonce = 32'h0;
        send_bytes(8'hF0, 2, 1'b0);
        send_bytes(8'hA0, 20, 1'b1);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL partial_load: got busy=%b rdy=%b required 0 1", busy, in_ready);
        end
        send_bytes(8'h50, 47, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL refirst_arm: got busy=%b required 1", busy);
        end
        tick();
        tick();
        checks++;
        if (sha_state !== ej[375:120] || message_head !== ej[119:24] ||
            difficulty_bm !== ej[23:8] || nonce_start_MSB !== ej[7:0] || pool_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL refirst_job: got sha=%h msb=%h prst=%b required %h %h 1",
                     sha_state, nonce_start_MSB, pool_reset_n, ej[375:120], ej[7:0]);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pool_reset_n !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_ctrl: got prst=%b rv=%b busy=%b rdy=%b required 0 0 0 0",
                     pool_reset_n, res_valid, busy, in_ready);
        end
        checks++;
        if (sha_state !== 256'h0 || message_head !== 96'h0 || difficulty_bm !== 16'h0 ||
            nonce_start_MSB !== 8'h00) begin
            errors++;
            $display("FAIL async_job: got sha=%h msb=%h required 0 0", sha_state, nonce_start_MSB);
        end
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || pool_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b prst=%b required 1 0", in_ready, pool_reset_n);
        end
    endtask

    initial begin
        in_data      = 8'h00;
        in_first     = 1'b0;
        in_valid     = 1'b0;
        abort        = 1'b0;
        res_ready    = 1'b0;
        pool_success = 1'b0;
        pool_nonce   = 32'h0;
        test_reset();
        test_load();
        test_success();
        test_backpressure();
        test_exhaust();
        test_priority();
        test_refirst();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
